// File: rtl/fm_qarctan.sv
// rtl/fm_qarctan.sv - quadrature arctangent stage: operand setup, divider handshake, quadrant correction
module fm_qarctan #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_angle,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic                  div_overflow,
  input  logic                  div_done
);

  localparam int DW = DATA_WIDTH;

  localparam logic [DW-1:0]          Q1      = DW'(QUAD1);
  localparam logic [DW-1:0]          Q3      = DW'(QUAD3);
  localparam logic signed [2*DW-1:0] Q1_WIDE = (2*DW)'(QUAD1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CALC  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Only the signs of x and y matter once the divider operands have been formed.
  logic          r_x_neg;
  logic          r_y_neg;
  logic [DW-1:0] r_dividend;
  logic [DW-1:0] r_divisor;
  logic [DW-1:0] r_quot;
  logic          r_ovf;
  logic [DW-1:0] r_angle;

  logic [DW-1:0]          w_abs_y;
  logic [DW-1:0]          w_dividend;
  logic [DW-1:0]          w_divisor;
  logic signed [2*DW-1:0] w_quot_wide;
  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW-1:0] w_shift;
  logic signed [2*DW-1:0] w_t;
  logic [DW-1:0]          w_base;
  logic [DW-1:0]          w_a;
  logic [DW-1:0]          w_angle;
  logic                   w_unused_t_hi;

  // Divider operands from the incoming sample; all arithmetic wraps at DW bits.
  always_comb begin
    w_abs_y = (in_y[DW-1] ? (~in_y + DW'(1)) : in_y) + DW'(1);
    if (!in_x[DW-1]) begin
      w_dividend = (in_x - w_abs_y) << BITS;
      w_divisor  = in_x + w_abs_y;
    end else begin
      w_dividend = (in_x + w_abs_y) << BITS;
      w_divisor  = w_abs_y - in_x;
    end
  end

  // Angle from the registered quotient: t = QUAD1*r / 2^BITS truncated toward zero.
  always_comb begin
    w_quot_wide = {{DW{r_quot[DW-1]}}, r_quot};
    w_prod      = Q1_WIDE * w_quot_wide;
    w_shift     = w_prod >>> BITS;
    // An arithmetic shift floors; bump negative non-exact results back toward zero.
    if (w_prod[2*DW-1] && (|w_prod[BITS-1:0])) begin
      w_t = w_shift + (2*DW)'(1);
    end else begin
      w_t = w_shift;
    end
    w_base  = r_x_neg ? Q3 : Q1;
    w_a     = w_base - w_t[DW-1:0];
    w_angle = r_ovf ? '0 : (r_y_neg ? (~w_a + DW'(1)) : w_a);
  end

  assign w_unused_t_hi = ^w_t[2*DW-1:DW];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs. CALC already presents the angle so that
  // out_valid rises the cycle after div_done; OUT holds it from r_angle.
  always_comb begin
    w_next    = S_IDLE;
    in_ready  = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = reset;
        w_next   = in_valid ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        div_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        w_next = div_done ? S_CALC : S_WAIT;
      end
      S_CALC: begin
        out_valid = 1'b1;
        w_next    = out_ready ? S_IDLE : S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        w_next    = out_ready ? S_IDLE : S_OUT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers: capture sample/operands, divider result, final angle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x_neg    <= 1'b0;
      r_y_neg    <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_ovf      <= 1'b0;
      r_angle    <= '0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_x_neg    <= in_x[DW-1];
        r_y_neg    <= in_y[DW-1];
        r_dividend <= w_dividend;
        r_divisor  <= w_divisor;
      end
      if (r_state == S_WAIT && div_done) begin
        r_quot <= div_quotient;
        r_ovf  <= div_overflow;
      end
      if (r_state == S_CALC) begin
        r_angle <= w_angle;
      end
    end
  end

  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign out_angle    = (r_state == S_CALC) ? w_angle : r_angle;

endmodule

// File: tb/tb_fm_qarctan.sv
// tb/tb_fm_qarctan.sv - directed self-checking bench for fm_qarctan
module tb_fm_qarctan;

  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_x = '0;
  logic signed [DW-1:0] in_y = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_angle;
  logic                 div_start;
  logic signed [DW-1:0] div_dividend;
  logic signed [DW-1:0] div_divisor;
  logic signed [DW-1:0] div_quotient = '0;
  logic                 div_overflow = 1'b0;
  logic                 div_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  fm_qarctan #(.DATA_WIDTH(DW), .BITS(10), .QUAD1(804), .QUAD3(2412)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_angle(out_angle),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_overflow(div_overflow), .div_done(div_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (div_start === 1'b1) start_cnt++;

  task automatic test_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_angle !== 32'sd0) begin errors++; $display("FAIL reset_out_angle got=%0d exp=0", out_angle); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got=%0b exp=0", div_start); end
    checks++; if (div_dividend !== 32'sd0 || div_divisor !== 32'sd0) begin errors++; $display("FAIL reset_operands got=%0d/%0d exp=0/0", div_dividend, div_divisor); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic run_txn(input string name, input logic signed [DW-1:0] x, input logic signed [DW-1:0] y,
                         input logic signed [DW-1:0] exp_dvd, input logic signed [DW-1:0] exp_dvs,
                         input logic signed [DW-1:0] q, input logic ovf,
                         input logic signed [DW-1:0] exp_ang, input int hold);
    int starts0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s idle_in_ready got=%0b exp=1", name, in_ready); end
    starts0  = start_cnt;
    in_valid = 1'b1; in_x = x; in_y = y;
    @(negedge clk);
    in_valid = 1'b0; in_x = 32'sh1234; in_y = -32'sh777;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL %s div_start got=%0b exp=1", name, div_start); end
    checks++; if (div_dividend !== exp_dvd) begin errors++; $display("FAIL %s dividend got=%0d exp=%0d", name, div_dividend, exp_dvd); end
    checks++; if (div_divisor !== exp_dvs) begin errors++; $display("FAIL %s divisor got=%0d exp=%0d", name, div_divisor, exp_dvs); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s issue_in_ready got=%0b exp=0", name, in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL %s start_width got=%0b exp=0 cyc=%0d", name, div_start, i); end
      checks++; if (div_dividend !== exp_dvd || div_divisor !== exp_dvs) begin errors++; $display("FAIL %s wait_operands got=%0d/%0d exp=%0d/%0d", name, div_dividend, div_divisor, exp_dvd, exp_dvs); end
    end
    div_done = 1'b1; div_quotient = q; div_overflow = ovf;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_out_valid got=%0b exp=0", name, out_valid); end
    @(negedge clk);
    div_done = 1'b0; div_quotient = 32'sh5a5a5a5; div_overflow = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got=%0b exp=1", name, out_valid); end
    checks++; if (out_angle !== exp_ang) begin errors++; $display("FAIL %s out_angle got=%0d exp=%0d", name, out_angle, exp_ang); end
    if (hold > 0) begin in_valid = 1'b1; in_x = 32'sd7; in_y = 32'sd9; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_angle !== exp_ang) begin errors++; $display("FAIL %s hold got=%0b/%0d exp=1/%0d cyc=%0d", name, out_valid, out_angle, exp_ang, i); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s hold_in_ready got=%0b exp=0 cyc=%0d", name, in_ready, i); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s drop_out_valid got=%0b exp=0", name, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s back_in_ready got=%0b exp=1", name, in_ready); end
    checks++; if (start_cnt - starts0 !== 1) begin errors++; $display("FAIL %s start_count got=%0d exp=1", name, start_cnt - starts0); end
  endtask

  task automatic test_basic();
    run_txn("x1024_y0", 32'sd1024, 32'sd0, 32'sd1047552, 32'sd1025, 32'sd1022, 1'b0, 32'sd2, 0);
  endtask

  task automatic test_quadrants();
    run_txn("x0_y1000", 32'sd0, 32'sd1000, -32'sd1025024, 32'sd1001, -32'sd1024, 1'b0, 32'sd1608, 0);
    run_txn("x0_yn1000", 32'sd0, -32'sd1000, -32'sd1025024, 32'sd1001, -32'sd1024, 1'b0, -32'sd1608, 0);
    run_txn("xn1000_y0", -32'sd1000, 32'sd0, -32'sd1022976, 32'sd1001, -32'sd1021, 1'b0, 32'sd3213, 0);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 32'sd1024, 32'sd0, 32'sd1047552, 32'sd1025, 32'sd1022, 1'b0, 32'sd2, 20);
  endtask

  task automatic test_overflow();
    run_txn("overflow", 32'sd5, 32'sd3, 32'sd1024, 32'sd9, 32'sd113, 1'b1, 32'sd0, 2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_x = 32'sd0; in_y = 32'sd1000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (div_dividend !== 32'sd0 || div_divisor !== 32'sd0) begin errors++; $display("FAIL midreset_operands got=%0d/%0d exp=0/0", div_dividend, div_divisor); end
    checks++; if (out_valid !== 1'b0 || div_start !== 1'b0 || in_ready !== 1'b0 || out_angle !== 32'sd0) begin errors++; $display("FAIL midreset_outputs got=%0b%0b%0b/%0d exp=000/0", out_valid, div_start, in_ready, out_angle); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL postreset_in_ready got=%0b exp=1", in_ready); end
    div_done = 1'b1; div_quotient = 32'sd123;
    @(negedge clk);
    div_done = 1'b0;
    checks++; if (out_valid !== 1'b0 || div_start !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stray_done got=%0b%0b%0b exp=001", out_valid, div_start, in_ready); end
    run_txn("after_reset", 32'sd1024, 32'sd0, 32'sd1047552, 32'sd1025, 32'sd1022, 1'b0, 32'sd2, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quadrants();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
